// File: rtl/fifo_fwft.sv
// fifo_fwft: parametrised single-clock FIFO with count, almost-full/empty,
// sticky overflow/underflow flags, synchronous flush and selectable read mode.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_flush              synchronous flush (priority over enq/deq)
//   i_clr_err            synchronous clear of o_overflow/o_underflow
//   enq_data/en/rdy      write side; enq_rdy = !o_full
//   deq_data/en/rdy      read side; deq_rdy = !o_empty
//                        p_FWFT=0: deq_data registered on a dequeue fire
//                        p_FWFT=1: deq_data shows the head word, deq_en pops
//   o_full, o_empty, o_count, o_almost_full, o_almost_empty   status
//   o_overflow, o_underflow                                   sticky errors
module fifo_fwft #(
   parameter int unsigned p_WORD_LEN  = 8,
   parameter int unsigned p_FIFO_SIZE = 8,
   parameter int unsigned p_FWFT      = 0,
   parameter int unsigned p_AF_LEVEL  = 6,
   parameter int unsigned p_AE_LEVEL  = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_flush,
   input  logic                          i_clr_err,
   input  logic [p_WORD_LEN-1:0]         enq_data,
   input  logic                          enq_en,
   output logic                          enq_rdy,
   output logic [p_WORD_LEN-1:0]         deq_data,
   input  logic                          deq_en,
   output logic                          deq_rdy,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(p_FIFO_SIZE):0]  o_count,
   output logic                          o_almost_full,
   output logic                          o_almost_empty,
   output logic                          o_overflow,
   output logic                          o_underflow
);

   localparam int unsigned lp_AW = $clog2(p_FIFO_SIZE);
   localparam int unsigned lp_PW = lp_AW + 1;

   // Elaboration-time parameter legality
   if (p_FIFO_SIZE < 2 || (p_FIFO_SIZE & (p_FIFO_SIZE - 1)) != 0) begin : g_bad_size
      $error("fifo_fwft: p_FIFO_SIZE must be a power of two >= 2");
   end
   if (p_AF_LEVEL < 1 || p_AF_LEVEL > p_FIFO_SIZE) begin : g_bad_af
      $error("fifo_fwft: p_AF_LEVEL must be in 1..p_FIFO_SIZE");
   end
   if (p_AE_LEVEL > p_FIFO_SIZE - 1) begin : g_bad_ae
      $error("fifo_fwft: p_AE_LEVEL must be in 0..p_FIFO_SIZE-1");
   end

   logic [lp_PW-1:0]      r_head;
   logic [lp_PW-1:0]      r_tail;
   logic [p_WORD_LEN-1:0] r_mem [p_FIFO_SIZE];
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic [lp_PW-1:0]      w_count;
   logic                  w_enq_fire;
   logic                  w_deq_fire;
   logic                  w_ovf_set;
   logic                  w_udf_set;
   logic [lp_AW-1:0]      w_tail_idx;

   // Status derives only from registered pointers; MSB is the wrap bit
   assign w_full     = (r_head[lp_AW] != r_tail[lp_AW]) &&
                       (r_head[lp_AW-1:0] == r_tail[lp_AW-1:0]);
   assign w_empty    = (r_head == r_tail);
   assign w_count    = r_head - r_tail;
   assign w_tail_idx = r_tail[lp_AW-1:0];

   // Flush suppresses both transfers and both error conditions
   assign w_enq_fire = enq_en & ~w_full  & ~i_flush;
   assign w_deq_fire = deq_en & ~w_empty & ~i_flush;
   assign w_ovf_set  = enq_en &  w_full  & ~i_flush;
   assign w_udf_set  = deq_en &  w_empty & ~i_flush;

   // Head/tail pointers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head <= '0;
         r_tail <= '0;
      end else if (i_flush) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_enq_fire) r_head <= r_head + lp_PW'(1);
         if (w_deq_fire) r_tail <= r_tail + lp_PW'(1);
      end
   end

   // Storage; contents intentionally not reset
   always_ff @(posedge i_clk) begin
      if (w_enq_fire) r_mem[r_head[lp_AW-1:0]] <= enq_data;
   end

   // Sticky error flags; a new error in the clear cycle wins
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_ovf_set | (r_overflow  & ~i_clr_err);
         r_underflow <= w_udf_set | (r_underflow & ~i_clr_err);
      end
   end

   // Read path selection
   if (p_FWFT != 0) begin : g_fwft
      // Head word presented directly; forced to zero while nothing is stored
      assign deq_data = w_empty ? '0 : r_mem[w_tail_idx];
   end else begin : g_reg
      logic [p_WORD_LEN-1:0] r_deq_data;
      // Loaded only on a dequeue fire; holds through flush
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)        r_deq_data <= '0;
         else if (w_deq_fire) r_deq_data <= r_mem[w_tail_idx];
      end
      assign deq_data = r_deq_data;
   end

   assign enq_rdy        = ~w_full;
   assign deq_rdy        = ~w_empty;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_count        = w_count;
   assign o_almost_full  = (w_count >= lp_PW'(p_AF_LEVEL));
   assign o_almost_empty = (w_count <= lp_PW'(p_AE_LEVEL));
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench: two instances (registered read and first-word fall-through)
// share all inputs, so status is identical and only deq_data differs.
module tb_fifo_fwft;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       clr_err;
   logic [7:0] enq_data;
   logic       enq_en;
   logic       deq_en;

   logic       enq_rdy0, deq_rdy0, full0, empty0, af0, ae0, ovf0, udf0;
   logic [7:0] d0;
   logic [3:0] cnt0;
   logic       enq_rdy1, deq_rdy1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [7:0] d1;
   logic [3:0] cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_fwft #(.p_WORD_LEN(8), .p_FIFO_SIZE(8), .p_FWFT(0),
               .p_AF_LEVEL(6), .p_AE_LEVEL(1)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
      .enq_data(enq_data), .enq_en(enq_en), .enq_rdy(enq_rdy0),
      .deq_data(d0), .deq_en(deq_en), .deq_rdy(deq_rdy0),
      .o_full(full0), .o_empty(empty0), .o_count(cnt0),
      .o_almost_full(af0), .o_almost_empty(ae0),
      .o_overflow(ovf0), .o_underflow(udf0));

   fifo_fwft #(.p_WORD_LEN(8), .p_FIFO_SIZE(8), .p_FWFT(1),
               .p_AF_LEVEL(6), .p_AE_LEVEL(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
      .enq_data(enq_data), .enq_en(enq_en), .enq_rdy(enq_rdy1),
      .deq_data(d1), .deq_en(deq_en), .deq_rdy(deq_rdy1),
      .o_full(full1), .o_empty(empty1), .o_count(cnt1),
      .o_almost_full(af1), .o_almost_empty(ae1),
      .o_overflow(ovf1), .o_underflow(udf1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
      enq_data = 8'h00; enq_en = 1'b0; deq_en = 1'b0;

      // Reset values before any clock edge
      #2;
      chk("rst_count", 32'(cnt0), 0);
      chk("rst_empty", 32'(empty0), 1);
      chk("rst_full", 32'(full0), 0);
      chk("rst_ae", 32'(ae0), 1);
      chk("rst_af", 32'(af0), 0);
      chk("rst_ovf", 32'(ovf0), 0);
      chk("rst_udf", 32'(udf0), 0);
      chk("rst_d0", 32'(d0), 0);
      chk("rst_enq_rdy", 32'(enq_rdy0), 1);
      chk("rst_deq_rdy", 32'(deq_rdy1), 0);
      tick();
      rst_n = 1'b1;

      // Fill 0x01..0x08, then overflow attempt
      for (int i = 1; i <= 8; i++) begin
         enq_data = 8'(i); enq_en = 1'b1;
         tick();
         chk("fill_count", 32'(cnt0), 32'(i));
         chk("fill_af", 32'(af0), (i >= 6) ? 1 : 0);
         chk("fill_ae", 32'(ae0), (i <= 1) ? 1 : 0);
         chk("fill_full", 32'(full0), (i == 8) ? 1 : 0);
         chk("fill_enq_rdy", 32'(enq_rdy0), (i == 8) ? 0 : 1);
      end
      enq_data = 8'h99;
      tick();
      enq_en = 1'b0;
      chk("ovf_set", 32'(ovf0), 1);
      chk("ovf_count", 32'(cnt0), 8);
      chk("ovf_udf", 32'(udf0), 0);

      // Drain back-to-back; registered data lags deq_en by one cycle
      for (int i = 1; i <= 8; i++) begin
         chk("drain_fwft_head", 32'(d1), 32'(i));
         deq_en = 1'b1;
         tick();
         chk("drain_d0", 32'(d0), 32'(i));
         chk("drain_count", 32'(cnt0), 32'(8 - i));
      end
      chk("drain_empty", 32'(empty0), 1);
      chk("drain_deq_rdy", 32'(deq_rdy1), 0);
      tick();
      deq_en = 1'b0;
      chk("udf_set", 32'(udf0), 1);
      chk("udf_d0_hold", 32'(d0), 8'h08);
      chk("udf_count", 32'(cnt0), 0);

      // Clear errors: takes effect at the edge
      clr_err = 1'b1;
      #1;
      chk("clr_pre_edge", 32'(ovf0), 1);
      tick();
      clr_err = 1'b0;
      chk("clr_ovf", 32'(ovf0), 0);
      chk("clr_udf", 32'(udf0), 0);

      // Fall-through presentation of a single word
      enq_data = 8'hA5; enq_en = 1'b1;
      tick();
      enq_en = 1'b0;
      chk("fwft_rdy", 32'(deq_rdy1), 1);
      chk("fwft_data", 32'(d1), 8'hA5);
      chk("fwft_count", 32'(cnt1), 1);
      tick();
      chk("fwft_hold", 32'(d1), 8'hA5);
      deq_en = 1'b1;
      tick();
      deq_en = 1'b0;
      chk("fwft_pop_rdy", 32'(deq_rdy1), 0);
      chk("fwft_pop_count", 32'(cnt1), 0);
      chk("fwft_pop_d0", 32'(d0), 8'hA5);

      // Steady state at count=3 with simultaneous enq/deq
      for (int i = 0; i < 3; i++) begin
         enq_data = 8'(8'h10 + i); enq_en = 1'b1;
         tick();
      end
      for (int k = 0; k < 20; k++) begin
         enq_data = 8'(8'h13 + k); enq_en = 1'b1; deq_en = 1'b1;
         chk("sim_fwft_head", 32'(d1), 32'(8'h10 + k));
         tick();
         chk("sim_count", 32'(cnt0), 3);
         chk("sim_d0", 32'(d0), 32'(8'h10 + k));
      end
      deq_en = 1'b0;

      // Refill to full (holding 0x24..0x2B), then enq+deq while full
      for (int i = 0; i < 5; i++) begin
         enq_data = 8'(8'h27 + i);
         tick();
      end
      chk("full2_full", 32'(full0), 1);
      chk("full2_enq_rdy", 32'(enq_rdy0), 0);
      enq_data = 8'hEE; enq_en = 1'b1; deq_en = 1'b1;
      chk("full2_fwft_old", 32'(d1), 8'h24);
      tick();
      enq_en = 1'b0; deq_en = 1'b0;
      chk("full2_count", 32'(cnt0), 7);
      chk("full2_ovf", 32'(ovf0), 1);
      chk("full2_d0", 32'(d0), 8'h24);
      chk("full2_next", 32'(d1), 8'h25);
      chk("full2_notfull", 32'(full0), 0);

      // Down to count=5, clear flags
      deq_en = 1'b1;
      tick();
      tick();
      deq_en = 1'b0;
      chk("pre_flush_count", 32'(cnt0), 5);
      chk("pre_flush_d0", 32'(d0), 8'h26);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("pre_flush_ovf", 32'(ovf0), 0);

      // Flush beats concurrent enq/deq and raises no flags
      flush = 1'b1; enq_en = 1'b1; deq_en = 1'b1; enq_data = 8'h55;
      tick();
      chk("flush_count", 32'(cnt0), 0);
      chk("flush_empty", 32'(empty0), 1);
      chk("flush_ovf", 32'(ovf0), 0);
      chk("flush_udf", 32'(udf0), 0);
      chk("flush_d0_hold", 32'(d0), 8'h26);
      tick();
      chk("flush_empty_udf", 32'(udf0), 0);
      chk("flush_empty_count", 32'(cnt0), 0);
      flush = 1'b0; deq_en = 1'b0;
      enq_data = 8'h66;
      tick();
      enq_en = 1'b0;
      chk("post_flush_head", 32'(d1), 8'h66);
      chk("post_flush_count", 32'(cnt1), 1);

      // Asynchronous reset between edges mid-burst
      enq_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         enq_data = 8'(8'h31 + i);
         tick();
      end
      chk("burst_count", 32'(cnt0), 4);
      #2;
      rst_n = 1'b0; enq_en = 1'b0;
      #1;
      chk("arst_count", 32'(cnt0), 0);
      chk("arst_empty", 32'(empty0), 1);
      chk("arst_full", 32'(full0), 0);
      chk("arst_ae", 32'(ae0), 1);
      chk("arst_d0", 32'(d0), 0);
      chk("arst_deq_rdy", 32'(deq_rdy1), 0);
      #1;
      rst_n = 1'b1;
      enq_data = 8'h77; enq_en = 1'b1;
      tick();
      enq_en = 1'b0;
      chk("after_rst_head", 32'(d1), 8'h77);
      chk("after_rst_count", 32'(cnt0), 1);
      deq_en = 1'b1;
      tick();
      deq_en = 1'b0;
      chk("after_rst_d0", 32'(d0), 8'h77);
      chk("after_rst_empty", 32'(empty0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_fwft.md
Name: fifo_fwft

Overview:
Parametrised synchronous FIFO. It is the next generation of the single-clock byte FIFO used between the I2C shift engine and the host register interface.
- Adds a count output, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Adds a synchronous flush.
- Enqueue and dequeue can fire in the same cycle.
- p_FWFT selects the read mode: registered read (legacy timing) or first-word fall-through.

Parameters:
p_WORD_LEN, 8, data word width in bits (>=1)
p_FIFO_SIZE, 8, depth in words; power of two, >=2
p_FWFT, 0, 0 = registered read, 1 = first-word fall-through
p_AF_LEVEL, 6, o_almost_full asserts when count >= this value; legal range 1..p_FIFO_SIZE
p_AE_LEVEL, 1, o_almost_empty asserts when count <= this value; legal range 0..p_FIFO_SIZE-1

Ports:
i_clk  in  1  clock; all state changes on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_flush  in  1  synchronous flush; empties the FIFO
i_clr_err  in  1  synchronous clear of o_overflow/o_underflow
enq_data  in  p_WORD_LEN  word to enqueue
enq_en  in  1  enqueue request
enq_rdy  out  1  FIFO can accept a word (= !o_full)
deq_data  out  p_WORD_LEN  dequeued word (mode 0) / head-of-queue word (mode 1)
deq_en  in  1  dequeue request (mode 0) / pop acknowledge (mode 1)
deq_rdy  out  1  a word is available (= !o_empty)
o_full  out  1  count == p_FIFO_SIZE
o_empty  out  1  count == 0
o_count  out  $clog2(p_FIFO_SIZE)+1  words stored, range 0..p_FIFO_SIZE
o_almost_full  out  1  count >= p_AF_LEVEL
o_almost_empty  out  1  count <= p_AE_LEVEL
o_overflow  out  1  sticky: enqueue attempted while full
o_underflow  out  1  sticky: dequeue attempted while empty

Behaviour:
- Reset (i_rst_n=0, asynchronous, takes effect immediately):
  - head and tail pointers = 0, count = 0, deq_data = 0
  - o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0
  - o_overflow=0, o_underflow=0
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words; the first accepted word after reset is the first word read.
- Pointers are $clog2(p_FIFO_SIZE)+1 bits. The MSB is the wrap bit.
  - full: low bits equal, wrap bits differ.
  - empty: pointers equal.
  - Pointers wrap modulo 2*p_FIFO_SIZE.
- All status outputs are combinational functions of the registered pointers. They reflect an edge's effect immediately after that edge. There is no combinational path from enq_en or deq_en to any ready or status output.
- Accept rules:
  - Enqueue fires when enq_en && enq_rdy: word is written at head, head+1.
  - Dequeue fires when deq_en && deq_rdy: tail+1.
  - Both may fire in the same cycle: data is stored and popped, and count is unchanged.
  - When full, enq_rdy=0 even if a dequeue fires in the same cycle.
- Mode 0 (p_FWFT=0):
  - On a dequeue fire, deq_data is loaded with mem[tail] at that edge, so the word is valid one cycle after the deq_en cycle.
  - deq_data holds its value otherwise, including through flush.
- Mode 1 (p_FWFT=1):
  - deq_data = mem[tail] whenever deq_rdy=1.
  - A word written into an empty FIFO is presented, with deq_rdy=1, in the cycle after the write edge.
  - A dequeue fire advances deq_data to the next word (or deq_rdy drops) after that edge.
  - deq_data is don't-care while deq_rdy=0.
  - In the full+deq cycle, the popped word is the old head, never the incoming word.
- Flush: i_flush=1 sets head = tail = 0 and count = 0 at the edge. It has priority over any enq/deq in the same cycle; neither fires, and the error flags are not set by that cycle. The error flags are otherwise unaffected by flush.
- Error flags:
  - o_overflow sets when enq_en=1 && o_full=1.
  - o_underflow sets when deq_en=1 && o_empty=1.
  - The rejected operation changes no other state.
  - i_clr_err clears both flags; a set condition in the same cycle wins over clear.
- Parameter checks: illegal p_FIFO_SIZE (not a power of two, or <2), p_AF_LEVEL or p_AE_LEVEL are a static elaboration error.

Test Plan:
(All with p_WORD_LEN=8, p_FIFO_SIZE=8, p_AF_LEVEL=6, p_AE_LEVEL=1.)
- Reset, then enqueue 0x01..0x08 on consecutive cycles, then one further enq -> after the 8th edge o_full=1, enq_rdy=0, o_count=8; extra enq sets o_overflow=1 and contents are unchanged; o_almost_full rises after the 6th edge; o_almost_empty falls after the 2nd edge.
- Mode 0: fill with 0x01..0x08, dequeue 8 times back-to-back -> deq_data = 0x01..0x08, each one cycle after its deq_en; o_empty=1 after the 8th edge; one more deq sets o_underflow=1 and deq_data stays 0x08.
- Mode 1: enqueue 0xA5 into an empty FIFO -> next cycle deq_rdy=1, deq_data=0xA5 with no deq_en; pop -> deq_rdy=0, o_count=0.
- Simultaneous enq/deq at count=3 for 20 cycles with incrementing data -> o_count stays 3; data out in order; pointers wrap at least twice.
- Full with simultaneous enq+deq -> dequeue fires, enqueue rejected with o_overflow=1, o_count=7.
- Flush with enq_en=deq_en=1 at count=5 -> o_count=0, o_empty=1, no flag set. Separately: assert i_rst_n=0 mid-burst between clock edges -> outputs reach reset values without a clock edge. i_clr_err clears the flags one edge later.
